// File: rtl/ds_1bit_adc_decim.sv
// Purpose : 1-bit delta-sigma ADC back end: pdm_in synchroniser, feedback flop,
//           modulator tick divider and a 3rd-order CIC decimator with a 16-bit saturated output.
// Latency : dout/dout_valid appear 2 clk after the DECIM-th modulator tick of each decimation period.
// Backpres: none; dout_valid is a one-clk strobe and dout holds until the next valid sample.
//
// Ports   : clk        - system clock, all logic on its rising edge
//           rst_n      - asynchronous active-low reset
//           pdm_in     - comparator output, asynchronous to clk
//           pdm_fb     - feedback bit to the external RC integrator, changes only on ticks
//           dout       - signed 16-bit decimated sample
//           dout_valid - one-clk strobe qualifying dout
//           sat        - (DS_ADC_SAT_EN only) high with dout_valid when that sample was clipped
//
// Build option: define DS_ADC_SAT_EN to add the sat port and its logic.

module ds_1bit_adc_decim #(
    parameter int DIV_RATIO = 100,  // clk cycles per modulator tick
    parameter int DECIM     = 64    // decimation ratio, power of two 16..256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pdm_in,
    output logic               pdm_fb,
    output logic signed [15:0] dout,
    output logic               dout_valid
`ifdef DS_ADC_SAT_EN
    ,
    output logic               sat
`endif
);

    localparam int LOG2D = $clog2(DECIM);
    localparam int W     = 3 * LOG2D + 2;              // CIC register width
    localparam int SHIFT = 3 * LOG2D - 15;             // negative for DECIM=16
    localparam int SHR   = (SHIFT > 0) ? SHIFT : 0;
    localparam int SHL   = (SHIFT < 0) ? -SHIFT : 0;
    localparam int SW    = W + 4;                      // room for the left-shift case
    localparam int CNT_W = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
    localparam int DC_W  = LOG2D;

    localparam logic signed [SW-1:0] POS_LIM = SW'(32767);
    localparam logic signed [SW-1:0] NEG_LIM = SW'(-32768);

    // state
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
    logic [DC_W-1:0]   dec_cnt_q, dec_cnt_d;
    logic [1:0]        warm_cnt_q, warm_cnt_d;
    logic              dec_stb_q, dec_stb_d;
    logic              pdm_fb_q, pdm_fb_d;
    logic [W-1:0]      i1_q, i1_d;
    logic [W-1:0]      i2_q, i2_d;
    logic [W-1:0]      i3_q, i3_d;
    logic [W-1:0]      d1_q, d1_d;
    logic [W-1:0]      d2_q, d2_d;
    logic [W-1:0]      d3_q, d3_d;
    logic signed [15:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
`ifdef DS_ADC_SAT_EN
    logic              sat_q, sat_d;
`endif

    // combinational helpers
    logic              cke;
    logic [W-1:0]      x_w;
    logic [W-1:0]      c1, c2, c3;
    logic signed [SW-1:0] c3_ext;
    logic signed [SW-1:0] scaled;
    logic              clip_hi, clip_lo;

    always_comb begin
        // tick divider: cke on the last count, counter wraps to 0 on the same edge
        cke       = (div_cnt_q == CNT_W'(DIV_RATIO - 1));
        div_cnt_d = cke ? '0 : div_cnt_q + CNT_W'(1);

        sync1_d = pdm_in;
        sync2_d = sync1_q;

        // bipolar sample: 1 -> +1, 0 -> -1 (all ones in W bits)
        x_w = sync2_q ? W'(1) : {W{1'b1}};

        pdm_fb_d  = pdm_fb_q;
        i1_d      = i1_q;
        i2_d      = i2_q;
        i3_d      = i3_q;
        dec_cnt_d = dec_cnt_q;
        if (cke) begin
            pdm_fb_d  = sync2_q;
            // each stage adds its predecessor's pre-update value
            i1_d      = i1_q + x_w;
            i2_d      = i2_q + i1_q;
            i3_d      = i3_q + i2_q;
            dec_cnt_d = (dec_cnt_q == DC_W'(DECIM - 1)) ? '0 : dec_cnt_q + DC_W'(1);
        end

        dec_stb_d = cke && (dec_cnt_q == DC_W'(DECIM - 1));

        // combs read i3_q, i.e. the value before any cke landing in the same cycle
        c1     = i3_q - d1_q;
        c2     = c1 - d2_q;
        c3     = c2 - d3_q;
        c3_ext = SW'($signed(c3));
        scaled = (c3_ext >>> SHR) <<< SHL;
        clip_hi = (scaled > POS_LIM);
        clip_lo = (scaled < NEG_LIM);

        d1_d         = d1_q;
        d2_d         = d2_q;
        d3_d         = d3_q;
        warm_cnt_d   = warm_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
`ifdef DS_ADC_SAT_EN
        sat_d        = 1'b0;
`endif
        if (dec_stb_q) begin
            d1_d = i3_q;
            d2_d = c1;
            d3_d = c2;
            // first three outputs are filter warm-up: state advances, output stays put
            if (warm_cnt_q != 2'd3) begin
                warm_cnt_d = warm_cnt_q + 2'd1;
            end else begin
                dout_valid_d = 1'b1;
                if (clip_hi) begin
                    dout_d = 16'sh7fff;
                end else if (clip_lo) begin
                    dout_d = 16'sh8000;
                end else begin
                    dout_d = scaled[15:0];
                end
`ifdef DS_ADC_SAT_EN
                sat_d = clip_hi | clip_lo;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            div_cnt_q    <= '0;
            dec_cnt_q    <= '0;
            warm_cnt_q   <= '0;
            dec_stb_q    <= 1'b0;
            pdm_fb_q     <= 1'b0;
            i1_q         <= '0;
            i2_q         <= '0;
            i3_q         <= '0;
            d1_q         <= '0;
            d2_q         <= '0;
            d3_q         <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
`ifdef DS_ADC_SAT_EN
            sat_q        <= 1'b0;
`endif
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            div_cnt_q    <= div_cnt_d;
            dec_cnt_q    <= dec_cnt_d;
            warm_cnt_q   <= warm_cnt_d;
            dec_stb_q    <= dec_stb_d;
            pdm_fb_q     <= pdm_fb_d;
            i1_q         <= i1_d;
            i2_q         <= i2_d;
            i3_q         <= i3_d;
            d1_q         <= d1_d;
            d2_q         <= d2_d;
            d3_q         <= d3_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
`ifdef DS_ADC_SAT_EN
            sat_q        <= sat_d;
`endif
        end
    end

    assign pdm_fb     = pdm_fb_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
`ifdef DS_ADC_SAT_EN
    assign sat        = sat_q;
`endif

endmodule

// File: tb/tb_ds_1bit_adc_decim.sv
// Bench for ds_1bit_adc_decim.
// u_slow uses the default parameters (tick cadence, alternating input); u_fast uses
// DIV_RATIO=1 so every clk is a tick and ticks coincide with the comb strobe.
// Expected samples come from a direct FIR evaluation of the CIC impulse response.

`timescale 1ns/1ps

module tb_ds_1bit_adc_decim;

    localparam int DIV_S = 100;
    localparam int DIV_F = 1;
    localparam int DEC   = 64;
    localparam int LEN   = 3 * (DEC - 1) + 1;   // CIC impulse response length
    localparam int NEV   = 6;                   // decimation events per fast run

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_s_n, rst_f_n, pdm_s, pdm_f;
    logic fb_s, fb_f, vld_s, vld_f;
    logic signed [15:0] dout_s, dout_f;
`ifdef DS_ADC_SAT_EN
    logic sat_s, sat_f;
`endif

    ds_1bit_adc_decim #(.DIV_RATIO(DIV_S), .DECIM(DEC)) u_slow (
        .clk        (clk),
        .rst_n      (rst_s_n),
        .pdm_in     (pdm_s),
        .pdm_fb     (fb_s),
        .dout       (dout_s),
        .dout_valid (vld_s)
`ifdef DS_ADC_SAT_EN
        ,
        .sat        (sat_s)
`endif
    );

    ds_1bit_adc_decim #(.DIV_RATIO(DIV_F), .DECIM(DEC)) u_fast (
        .clk        (clk),
        .rst_n      (rst_f_n),
        .pdm_in     (pdm_f),
        .pdm_fb     (fb_f),
        .dout       (dout_f),
        .dout_valid (vld_f)
`ifdef DS_ADC_SAT_EN
        ,
        .sat        (sat_f)
`endif
    );

    int passed = 0;
    int total  = 0;

    // clk count since reset release (number of rising edges seen)
    int cyc_s, cyc_f;
    always @(posedge clk or negedge rst_s_n)
        if (!rst_s_n) cyc_s <= 0; else cyc_s <= cyc_s + 1;
    always @(posedge clk or negedge rst_f_n)
        if (!rst_f_n) cyc_f <= 0; else cyc_f <= cyc_f + 1;

    typedef struct {
        int cyc;
        int val;
        bit s;
    } ev_t;

    ev_t ev_s[$];
    ev_t ev_f[$];
    int  fb_t[$];
    int  xs_s[$];
    int  xs_f[$];
    int  h[LEN];
    logic fb_prev_s = 1'b0;
    bit  seen_f, warm_nz_f;

    // monitor: samples outputs on the falling edge
    always @(negedge clk) begin
        ev_t e;
        if (rst_s_n) begin
            if (vld_s) begin
                e.cyc = cyc_s;
                e.val = int'(dout_s);
`ifdef DS_ADC_SAT_EN
                e.s = sat_s;
`else
                e.s = 1'b0;
`endif
                ev_s.push_back(e);
            end
            if (fb_s !== fb_prev_s) fb_t.push_back(cyc_s);
        end
        fb_prev_s = fb_s;
        if (rst_f_n) begin
            if (vld_f) begin
                e.cyc = cyc_f;
                e.val = int'(dout_f);
`ifdef DS_ADC_SAT_EN
                e.s = sat_f;
`else
                e.s = 1'b0;
`endif
                ev_f.push_back(e);
                seen_f = 1'b1;
            end
            if (!seen_f && dout_f !== 16'sd0) warm_nz_f = 1'b1;
        end
    end

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    // CIC output for decimation event k (1-based). The integrator chain adds each
    // predecessor's old value, so the cascade carries a 2-sample delay: the newest
    // sample contributing to event k is sample DEC*k-2 (samples numbered from 1).
    function automatic int model_y(input bit fast, input int k);
        int acc = 0;
        int n;
        for (int j = 0; j < LEN; j++) begin
            n = DEC * k - 2 - j;
            if (n >= 1) acc += h[j] * (fast ? xs_f[n-1] : xs_s[n-1]);
        end
        return acc;
    endfunction

    function automatic int clip16(input int y);
        int v = y >>> 3;
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic bit clipped(input int y);
        int v = y >>> 3;
        return (v > 32767) || (v < -32768);
    endfunction

    function automatic bit pattern(input int kind, input int t);
        case (kind)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return (t % 2) == 0;
            3:       return (t % 4) != 3;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // fast instance: called with rst_f_n low; releases reset and runs NEV decimations.
    // const_exp < -40000 means "no fixed expectation" (random input).
    task automatic run_fast(input int kind, input string name, input int const_exp);
        int y;
        int n;
        ev_f.delete();
        xs_f.delete();
        // first two ticks after release read the cleared synchroniser (0 -> -1)
        xs_f.push_back(-1);
        xs_f.push_back(-1);
        seen_f    = 1'b0;
        warm_nz_f = 1'b0;
        @(negedge clk);
        rst_f_n = 1'b1;
        for (int t = 0; t < NEV * DEC; t++) begin
            pdm_f = pattern(kind, t);
            xs_f.push_back(pdm_f ? 1 : -1);
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check($sformatf("%s n_valid", name), ev_f.size(), NEV - 3);
        n = (ev_f.size() < NEV - 3) ? ev_f.size() : NEV - 3;
        for (int i = 0; i < n; i++) begin
            y = model_y(1'b1, i + 4);
            check($sformatf("%s ev%0d cyc", name, i + 4), ev_f[i].cyc, DEC * (i + 4) + 1);
            check($sformatf("%s ev%0d dout", name, i + 4), ev_f[i].val, clip16(y));
            if (const_exp >= -40000)
                check($sformatf("%s ev%0d dout_const", name, i + 4), ev_f[i].val, const_exp);
`ifdef DS_ADC_SAT_EN
            check($sformatf("%s ev%0d sat", name, i + 4), ev_f[i].s, clipped(y));
`endif
        end
        check($sformatf("%s warmup_dout_zero", name), warm_nz_f, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int y;
        int n;

        // triple boxcar impulse response
        for (int i = 0; i < LEN; i++) h[i] = 0;
        for (int a = 0; a < DEC; a++)
            for (int b = 0; b < DEC; b++)
                for (int c = 0; c < DEC; c++)
                    h[a + b + c]++;

        rst_s_n = 1'b0;
        rst_f_n = 1'b0;
        pdm_s   = 1'b1;
        pdm_f   = 1'b1;
        repeat (5) @(negedge clk);

        check("rst slow pdm_fb", fb_s, 0);
        check("rst slow dout", dout_s, 0);
        check("rst slow dout_valid", vld_s, 0);
        check("rst fast pdm_fb", fb_f, 0);
        check("rst fast dout", dout_f, 0);
        check("rst fast dout_valid", vld_f, 0);
`ifdef DS_ADC_SAT_EN
        check("rst slow sat", sat_s, 0);
`endif

        // default instance: alternating 1,0 per tick for 5 decimation periods
        rst_s_n = 1'b1;
        for (int t = 0; t < 5 * DEC; t++) begin
            pdm_s = (t % 2) == 0;
            xs_s.push_back(pdm_s ? 1 : -1);
            repeat (DIV_S) @(negedge clk);
        end
        repeat (3) @(negedge clk);

        check("slow fb transitions", fb_t.size(), 5 * DEC);
        n = (fb_t.size() < 5 * DEC) ? fb_t.size() : 5 * DEC;
        for (int i = 0; i < n; i++)
            check($sformatf("slow fb edge%0d cyc", i + 1), fb_t[i], DIV_S * (i + 1));
        check("slow n_valid", ev_s.size(), 2);
        n = (ev_s.size() < 2) ? ev_s.size() : 2;
        for (int i = 0; i < n; i++) begin
            y = model_y(1'b0, i + 4);
            check($sformatf("slow ev%0d cyc", i + 4), ev_s[i].cyc, DIV_S * DEC * (i + 4) + 1);
            check($sformatf("slow ev%0d dout", i + 4), ev_s[i].val, clip16(y));
            check($sformatf("slow ev%0d dout_const", i + 4), ev_s[i].val, 0);
        end
        if (ev_s.size() >= 2)
            check("slow valid period", ev_s[1].cyc - ev_s[0].cyc, DIV_S * DEC);
        rst_s_n = 1'b0;

        // fast instance: directed patterns
        run_fast(0, "ones", 32767);

        // reset in the middle of a decimation period
        repeat (30) @(negedge clk);
        check("pre-rst fast pdm_fb", fb_f, 1);
        check("pre-rst fast dout", dout_f, 32767);
        #2;
        rst_f_n = 1'b0;
        #1;
        check("mid-rst fast pdm_fb", fb_f, 0);
        check("mid-rst fast dout", dout_f, 0);
        check("mid-rst fast dout_valid", vld_f, 0);
`ifdef DS_ADC_SAT_EN
        check("mid-rst fast sat", sat_f, 0);
`endif
        run_fast(0, "ones_after_rst", 32767);

        @(negedge clk); rst_f_n = 1'b0;
        run_fast(1, "zeros", -32768);
        @(negedge clk); rst_f_n = 1'b0;
        run_fast(2, "alt10", 0);
        @(negedge clk); rst_f_n = 1'b0;
        run_fast(3, "p1110", 16384);
        @(negedge clk); rst_f_n = 1'b0;
        run_fast(4, "rand_a", -50000);
        @(negedge clk); rst_f_n = 1'b0;
        run_fast(4, "rand_b", -50000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ds_1bit_adc_decim.md
DS_1BIT_ADC_DECIM -- requirements
Module: ds_1bit_adc_decim

Interface
REQ-001 SHALL have parameter DIV_RATIO, default 100, meaning clk cycles per modulator tick (50 MHz / 100 = 500 kHz).
REQ-002 SHALL have parameter DECIM, default 64, meaning the decimation ratio; a power of two from 16 to 256.
REQ-003 SHALL have port clk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-005 SHALL have port pdm_in, input, 1 bit, the external comparator output; it is asynchronous to clk.
REQ-006 SHALL have port pdm_fb, output, 1 bit, the feedback bit driven to the external RC integrator.
REQ-007 SHALL have port dout, output, 16 bits signed, the decimated sample.
REQ-008 SHALL have port dout_valid, output, 1 bit, a one-clk strobe that qualifies dout.
REQ-009 SHALL have port sat, output, 1 bit, present only when DS_ADC_SAT_EN is defined (see Configuration).

Function
REQ-010 SHALL synchronise pdm_in through two clk flops before any use.
REQ-011 SHALL generate the internal strobe cke high for exactly one clk every DIV_RATIO clks; the divider counts 0..DIV_RATIO-1 and cke asserts on the wrap.
REQ-012 SHALL, on each cke, load pdm_fb with the synchronised bit, so pdm_fb changes only on cke cycles.
REQ-013 SHALL map each sample x as pdm_fb 1 -> +1 and 0 -> -1.
REQ-014 SHALL implement a 3rd-order CIC: three integrators updated only on cke (i1+=x, i2+=i1, i3+=i2, each using the pre-update value of its predecessor).
REQ-015 SHALL size the integrators at W = 3*log2(DECIM)+2 bits (20 for the default) using two's-complement wrap-around; overflow wrap is required, not an error.
REQ-016 SHALL count cke pulses modulo DECIM; a cke at count DECIM-1 sets dec_stb high for the following clk (cycle N+1).
REQ-017 SHALL, on dec_stb, compute the three combs combinationally from i3 (c1=i3-d1, c2=c1-d2, c3=c2-d3, mod 2^W), register the result, and update the delays d1..d3.
REQ-018 SHALL scale c3 by an arithmetic right shift of 3*log2(DECIM)-15, then saturate to [-32768, 32767].
REQ-019 SHALL drive dout and a one-clk dout_valid at cycle N+2, where N is the cke cycle of REQ-016; dout holds until the next update.
REQ-020 SHALL suppress dout_valid for the first 3 decimation events after reset (filter warm-up) while still updating internal state; dout stays 0 during warm-up.
REQ-021 SHALL, when a cke coincides with dec_stb, perform both actions in the same cycle, with the comb stage reading the i3 value before that cke's update.

Reset
REQ-022 SHALL, while rst_n is low, immediately clear the divider, the decimation counter, the warm-up counter, the synchroniser, all integrators, comb delays and dec_stb.
REQ-023 SHALL, while rst_n is low, hold pdm_fb=0, dout=0, dout_valid=0 and sat=0.
REQ-024 SHALL treat reset asserted mid-decimation as discarding the partial sample; after release, warm-up (REQ-020) restarts.
REQ-025 SHALL produce no cke until DIV_RATIO clks after rst_n deasserts.

Configuration
REQ-026 SHALL, when DS_ADC_SAT_EN is defined, provide port sat, which asserts with dout_valid for one clk when REQ-018 clipped that sample.
REQ-027 SHALL, when DS_ADC_SAT_EN is undefined, omit the sat port and its logic while still saturating dout.

Verification
REQ-028 SHALL cover: pdm_in held 1 -> after warm-up every dout=32767 and sat=1 (raw +32768 clipped).
REQ-029 SHALL cover: pdm_in held 0 -> dout=-32768, sat=0.
REQ-030 SHALL cover: pdm_in alternating 1,0 per cke -> dout=0 on every valid sample.
REQ-031 SHALL cover: repeating pattern 1,1,1,0 per cke -> dout=16384 on every valid sample.
REQ-032 SHALL cover cadence: with defaults, pdm_fb transitions only every 100 clks, and dout_valid pulses every 6400 clks, exactly 2 clks after the 64th cke.
REQ-033 SHALL cover: rst_n pulsed low mid-decimation -> outputs are 0 immediately, and the first dout_valid occurs at the 4th decimation event after release.
